multicycle_control: RTL

- Sequencing FSM for the multicycle LEGv8 datapath, the successor to the single-cycle processor.
- Breaks each instruction into FETCH/DECODE/EXEC/MEM/WB steps, so one ALU and one shared memory port are reused across cycles.
- Drives the datapath strobes that the single-cycle decoder produced combinationally: reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, aluop, signop.
- Also owns the PC/IR write enables and a bounded wait on a variable-latency memory handshake.

---
 rtl/mc_pkg.sv | 69 ++++++
 rtl/mc_opdecode.sv | 33 +++
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle LEGv8 control unit.
package mc_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        RST_S  = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_e;

    // Instruction classes produced by the opcode decoder
    typedef enum logic [3:0] {
        R_ADD = 4'd0,
        R_SUB = 4'd1,
        R_AND = 4'd2,
        R_ORR = 4'd3,
        LDUR  = 4'd4,
        STUR  = 4'd5,
        CBZ   = 4'd6,
        B     = 4'd7,
        MOVZ  = 4'd8,
        ILL   = 4'd9
    } insn_class_e;

    // Full 11-bit opcodes
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    // Prefix-matched opcodes (low bits belong to immediate fields)
    localparam logic [7:0] OP_CBZ_PFX  = 8'b10110100;
    localparam logic [5:0] OP_B_PFX    = 6'b000101;
    localparam logic [8:0] OP_MOVZ_PFX = 9'b110100101;

    // ALU operation select
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    // Immediate extension format select
    localparam logic [2:0] SIGN_I    = 3'b000;
    localparam logic [2:0] SIGN_D    = 3'b001;
    localparam logic [2:0] SIGN_B    = 3'b010;
    localparam logic [2:0] SIGN_CB   = 3'b011;
    localparam logic [2:0] SIGN_MOVZ = 3'b100;

    // ALU operation for the register-register classes
    function automatic logic [3:0] rtype_aluop(input insn_class_e c);
        logic [3:0] op;
        op = ALU_ADD;
        case (c)
            R_SUB:   op = ALU_SUB;
            R_AND:   op = ALU_AND;
            R_ORR:   op = ALU_ORR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode-to-class mapping; also used by the single-cycle
// control so both decoders can be cross-checked against each other.
module mc_opdecode
    import mc_pkg::*;
(
    input  logic [10:0]  i_opcode,
    output insn_class_e  o_class
);

    // Exact matches first, then prefix matches; anything else is illegal
    always_comb begin
        o_class = ILL;
        if (i_opcode == OP_LDUR)
            o_class = LDUR;
        else if (i_opcode == OP_STUR)
            o_class = STUR;
        else if (i_opcode == OP_ADD)
            o_class = R_ADD;
        else if (i_opcode == OP_SUB)
            o_class = R_SUB;
        else if (i_opcode == OP_AND)
            o_class = R_AND;
        else if (i_opcode == OP_ORR)
            o_class = R_ORR;
        else if (i_opcode[10:3] == OP_CBZ_PFX)
            o_class = CBZ;
        else if (i_opcode[10:5] == OP_B_PFX)
            o_class = B;
        else if (i_opcode[10:2] == OP_MOVZ_PFX)
            o_class = MOVZ;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes, and bounds the wait on the shared memory handshake.
//
// state  | meaning
// RST_S  | idle after reset, all outputs low
// FETCH  | read instruction, load IR on mem_ready
// DECODE | latch class; illegal opcodes retire here
// EXEC   | ALU step; CBZ/B retire here
// MEM    | data access for LDUR/STUR; STUR retires here
// WB     | register write, retire
// FAULT  | memory timeout, sticky until reset
module multicycle_control
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memread,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic [3:0]  aluop,
    output logic [2:0]  signop,
    output logic        pcwrite,
    output logic        pcsrc,
    output logic        instr_done,
    output logic        illegal,
    output logic        fault
);

    state_e            r_state;
    insn_class_e       r_class;
    logic [CNT_W-1:0]  r_cnt;

    insn_class_e       w_class;
    logic              w_limit;
    logic [CNT_W-1:0]  w_cnt_next;

    mc_opdecode u_opdecode (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    // Wait counter saturates at the limit; the limit cycle itself triggers FAULT
    assign w_limit    = (r_cnt == CNT_W'(WAIT_LIMIT));
    assign w_cnt_next = w_limit ? r_cnt : r_cnt + CNT_W'(1);

    // State, latched class and wait counter; counter clears on every transition
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= RST_S;
            r_class <= R_ADD;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RST_S: begin
                    r_state <= FETCH;
                    r_cnt   <= '0;
                end
                FETCH: begin
                    if (mem_ready) begin
                        r_state <= DECODE;
                        r_cnt   <= '0;
                    end else if (w_limit) begin
                        r_state <= FAULT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                DECODE: begin
                    r_class <= w_class;
                    r_cnt   <= '0;
                    r_state <= (w_class == ILL) ? FETCH : EXEC;
                end
                EXEC: begin
                    r_cnt <= '0;
                    case (r_class)
                        CBZ, B, ILL: r_state <= FETCH;
                        LDUR, STUR:  r_state <= MEM;
                        default:     r_state <= WB;
                    endcase
                end
                MEM: begin
                    if (mem_ready) begin
                        r_state <= (r_class == STUR) ? FETCH : WB;
                        r_cnt   <= '0;
                    end else if (w_limit) begin
                        r_state <= FAULT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                WB: begin
                    r_state <= FETCH;
                    r_cnt   <= '0;
                end
                FAULT: begin
                    r_state <= FAULT;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= RST_S;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Strobes decoded from state and class so reset silences them immediately
    always_comb begin
        mem_req    = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        reg2loc    = 1'b0;
        alusrc     = 1'b0;
        mem2reg    = 1'b0;
        aluop      = ALU_AND;
        signop     = SIGN_I;
        pcwrite    = 1'b0;
        pcsrc      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req = 1'b1;
                memread = 1'b1;
                irwrite = mem_ready;
            end
            DECODE: begin
                // Class is not latched yet, so use the live decode here
                reg2loc = (w_class == STUR) || (w_class == CBZ);
                if (w_class == ILL) begin
                    illegal    = 1'b1;
                    pcwrite    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            EXEC: begin
                case (r_class)
                    R_ADD, R_SUB, R_AND, R_ORR: begin
                        aluop = rtype_aluop(r_class);
                    end
                    LDUR, STUR: begin
                        aluop  = ALU_ADD;
                        alusrc = 1'b1;
                        signop = SIGN_D;
                    end
                    MOVZ: begin
                        aluop  = ALU_PASSB;
                        alusrc = 1'b1;
                        signop = SIGN_MOVZ;
                    end
                    CBZ: begin
                        aluop      = ALU_PASSB;
                        reg2loc    = 1'b1;
                        signop     = SIGN_CB;
                        pcwrite    = 1'b1;
                        pcsrc      = zero;
                        instr_done = 1'b1;
                    end
                    B: begin
                        signop     = SIGN_B;
                        pcwrite    = 1'b1;
                        pcsrc      = 1'b1;
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                if (r_class == LDUR)
                    memread = 1'b1;
                if (r_class == STUR) begin
                    memwrite   = 1'b1;
                    reg2loc    = 1'b1;
                    pcwrite    = mem_ready;
                    instr_done = mem_ready;
                end
            end
            WB: begin
                regwrite   = 1'b1;
                mem2reg    = (r_class == LDUR);
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
